memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state updates on the rising edge.
REQ-002 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port iREN, input, 1, instruction-cache read request.
REQ-004 SHALL have port iaddr, input, 32, instruction read address.
REQ-005 SHALL have port iwait, output, 1, instruction request not complete this cycle.
REQ-006 SHALL have port iload, output, 32, instruction read data.
REQ-007 SHALL have port dREN, input, 1, data-cache read request.
REQ-008 SHALL have port dWEN, input, 1, data-cache write request.
REQ-009 SHALL have port daddr, input, 32, data address.
REQ-010 SHALL have port dstore, input, 32, data write value.
REQ-011 SHALL have port dwait, output, 1, data request not complete this cycle.
REQ-012 SHALL have port dload, output, 32, data read value.
REQ-013 SHALL have ports ramREN, output, 1, and ramWEN, output, 1, RAM read and write strobes.
REQ-014 SHALL have ports ramaddr, output, 32, and ramstore, output, 32, RAM address and write data.
REQ-015 SHALL have port ramload, input, 32, RAM read data.
REQ-016 SHALL have port ramstate, input, 2, RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-017 SHALL implement a registered FSM with states IDLE, DGRANT and IGRANT.
REQ-018 SHALL hold a registered flag last_grant (I or D) recording the requester whose transfer last completed.
REQ-019 In IDLE, SHALL move to DGRANT if dREN|dWEN and (no iREN, or last_grant=I); SHALL move to IGRANT if iREN and (no D request, or last_grant=D); SHALL otherwise stay in IDLE.
REQ-020 In IDLE, SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0 and dload=0.
REQ-021 In DGRANT, SHALL drive ramaddr=daddr and ramstore=dstore; when dWEN=1, SHALL drive ramWEN=1 and ramREN=0 (write wins over read); otherwise SHALL drive ramREN=dREN and ramWEN=0.
REQ-022 In IGRANT, SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0 and ramstore=0.
REQ-023 In a grant state with ramstate=ACCESS, SHALL drive the granted requester's wait to 0 for that cycle only, set last_grant to that requester, and return to IDLE.
REQ-024 On a DGRANT read completion, SHALL drive dload=ramload; on an IGRANT completion, SHALL drive iload=ramload; both are combinational, valid in the ACCESS cycle only, and 0 in all other cycles.
REQ-025 In a grant state with ramstate FREE, BUSY or ERROR, SHALL stay in that grant state with both waits at 1, so an ERROR cycle is retried.
REQ-026 The non-granted requester's wait SHALL be 1 in every cycle.
REQ-027 If the granted requester withdraws its request (DGRANT with dREN=dWEN=0, or IGRANT with iREN=0), SHALL deassert the RAM strobes in that cycle, return to IDLE, and leave last_grant unchanged.
REQ-028 Requesters SHALL hold address, data and strobes stable until their wait drops; the arbiter SHALL NOT latch requester address or data.
REQ-029 Minimum latency SHALL be 2 cycles: request seen in IDLE, grant registered, wait drops in the first cycle with ramstate=ACCESS.
REQ-030 With both requesters continuously active, grants SHALL alternate D, I, D, I, ...

Reset
REQ-031 On nRST low, SHALL asynchronously set state=IDLE and last_grant=I, so D wins the first conflict.
REQ-032 Outputs during reset SHALL match REQ-020.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer, with no wait drop and no completion.

Verification
REQ-034 Idle read: iREN=1, iaddr=0x40, ramstate=ACCESS from cycle 2 with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 in cycle 2; iwait=0 and iload=0x8C010004 in cycle 2; IDLE in cycle 3.
REQ-035 Conflict after reset: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramstate=ACCESS -> D is served first with ramWEN=1 and ramstore=0xDEADBEEF; I is served in the next grant, with iwait=1 throughout the D transfer.
REQ-036 Busy/error stall: IGRANT with ramstate sequence BUSY, ERROR, BUSY, ACCESS -> iwait=1 for three cycles and 0 on the fourth; ramaddr is stable throughout.
REQ-037 Fairness: iREN and dREN held high for 8 completions -> grant order D, I, D, I, D, I, D, I.
REQ-038 Withdraw: DGRANT, then dREN=0 before ACCESS -> ramREN=0 in the same cycle, IDLE next cycle, last_grant unchanged; a pending iREN is then granted per REQ-019.
REQ-039 Async reset pulse during an IGRANT BUSY cycle -> outputs immediately match REQ-020; the next request is arbitrated with last_grant=I.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter: instruction and data caches share one RAM port.
// Conflicts are resolved by alternating on the requester that last completed.
module memory_arbiter (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);
   // state  | meaning
   // IDLE   | no owner; arbitrate pending requests
   // DGRANT | data cache owns the RAM until ACCESS or withdraw
   // IGRANT | instruction cache owns the RAM until ACCESS or withdraw
   typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   state_t state;
   logic   last_grant;
   logic   d_req;
   logic   access;

   assign d_req  = dREN | dWEN;
   assign access = (ramstate == RAM_ACCESS);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         case (state)
            IDLE: begin
               if (d_req && (!iREN || last_grant == GRANT_I))
                  state <= DGRANT;
               else if (iREN && (!d_req || last_grant == GRANT_D))
                  state <= IGRANT;
            end
            DGRANT: begin
               // a withdrawn request never counts as a completion
               if (!d_req) begin
                  state <= IDLE;
               end else if (access) begin
                  state      <= IDLE;
                  last_grant <= GRANT_D;
               end
            end
            IGRANT: begin
               if (!iREN) begin
                  state <= IDLE;
               end else if (access) begin
                  state      <= IDLE;
                  last_grant <= GRANT_I;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      case (state)
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (d_req && access) begin
               dwait = 1'b0;
               if (!dWEN)
                  dload = ramload;
            end
         end
         IGRANT: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (iREN && access) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations,
// then randomized requesters checked every cycle against a behavioural model.
module tb_memory_arbiter;
   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   logic [1:0]  ramstate = 2'd0;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;

   memory_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Behavioural model: who owns the RAM (0 none, 1 data, 2 instruction)
   // and whether the data side completed most recently.
   int   m_own = 0, nx_own = 0;
   logic m_last_d = 1'b0, nx_last_d = 1'b0;
   logic done_d = 1'b0, done_i = 1'b0;
   bit   cmp_en = 1'b0;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_own    <= 0;
         m_last_d <= 1'b0;
      end else begin
         m_own    <= nx_own;
         m_last_d <= nx_last_d;
      end
   end

   always @(negedge CLK) begin
      logic        e_ren, e_wen, e_iw, e_dw, dreq;
      logic [31:0] e_addr, e_store, e_iload, e_dload;
      e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
      e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
      dreq = dREN | dWEN;
      nx_own = m_own; nx_last_d = m_last_d; done_d = 0; done_i = 0;
      if (!nRST) begin
         nx_own = 0;
      end else if (m_own == 0) begin
         if (dreq && (!iREN || !m_last_d)) nx_own = 1;
         else if (iREN && (!dreq || m_last_d)) nx_own = 2;
      end else if (m_own == 1) begin
         e_addr = daddr; e_store = dstore;
         e_wen = dWEN; e_ren = dREN && !dWEN;
         if (!dreq) nx_own = 0;
         else if (ramstate == 2'd2) begin
            e_dw = 0;
            e_dload = dWEN ? 32'd0 : ramload;
            nx_own = 0; nx_last_d = 1; done_d = 1;
         end
      end else begin
         e_addr = iaddr; e_ren = iREN;
         if (!iREN) nx_own = 0;
         else if (ramstate == 2'd2) begin
            e_iw = 0; e_iload = ramload;
            nx_own = 0; nx_last_d = 0; done_i = 1;
         end
      end
      if (cmp_en) begin
         chk("model_ctl{ren,wen,iw,dw}", {28'd0, ramREN, ramWEN, iwait, dwait},
             {28'd0, e_ren, e_wen, e_iw, e_dw});
         chk("model_ramaddr", ramaddr, e_addr);
         chk("model_ramstore", ramstore, e_store);
         chk("model_iload", iload, e_iload);
         chk("model_dload", dload, e_dload);
      end
   end

   // Randomized requesters: hold a request until it completes, rarely withdraw.
   bit rand_en = 1'b0;
   bit d_pend = 1'b0, i_pend = 1'b0;
   always @(posedge CLK) begin
      #1;
      if (rand_en) begin
         if (d_pend && (done_d || $urandom_range(0, 31) == 0)) begin
            d_pend = 0; dREN = 0; dWEN = 0;
         end
         if (!d_pend) begin
            daddr = $urandom; dstore = $urandom;
            if ($urandom_range(0, 2) == 0) begin
               d_pend = 1;
               case ($urandom_range(0, 2))
                  0: begin dREN = 1; dWEN = 0; end
                  1: begin dREN = 0; dWEN = 1; end
                  default: begin dREN = 1; dWEN = 1; end
               endcase
            end
         end
         if (i_pend && (done_i || $urandom_range(0, 31) == 0)) begin
            i_pend = 0; iREN = 0;
         end
         if (!i_pend) begin
            iaddr = $urandom;
            if ($urandom_range(0, 2) == 0) begin
               i_pend = 1; iREN = 1;
            end
         end
         ramstate = 2'($urandom_range(0, 3));
         ramload  = $urandom;
      end
   end

   byte   order[$];
   string exp_order = "DIDIDIDI";
   logic [1:0] stall_seq [4] = '{2'd1, 2'd3, 2'd1, 2'd2};
   logic       stall_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      cmp_en = 1;
      repeat (2) @(posedge CLK);
      #3;
      chk("rst_ramREN", ramREN, 0);
      chk("rst_waits", {iwait, dwait}, 2'b11);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_iload", iload, 0);
      @(negedge CLK);
      nRST = 1;

      // idle instruction read
      tick(); iREN = 1; iaddr = 32'h40; ramstate = 2; ramload = 32'h8C010004; #2;
      chk("A_c1_iwait", iwait, 1);
      chk("A_c1_ramREN", ramREN, 0);
      tick(); #2;
      chk("A_c2_ramREN", ramREN, 1);
      chk("A_c2_ramaddr", ramaddr, 32'h40);
      chk("A_c2_iwait", iwait, 0);
      chk("A_c2_iload", iload, 32'h8C010004);
      tick(); iREN = 0; #2;
      chk("A_c3_iwait", iwait, 1);
      chk("A_c3_iload", iload, 0);
      chk("A_c3_ramaddr", ramaddr, 0);

      // conflict right after reset: data first
      tick(); #1 nRST = 0; #1 nRST = 1;
      tick(); iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      ramstate = 2; ramload = 32'h11111111; #2;
      chk("B_idle_waits", {iwait, dwait}, 2'b11);
      tick(); #2;
      chk("B_d_strobes", {ramWEN, ramREN}, 2'b10);
      chk("B_d_ramaddr", ramaddr, 32'h100);
      chk("B_d_ramstore", ramstore, 32'hDEADBEEF);
      chk("B_d_waits", {iwait, dwait}, 2'b10);
      chk("B_d_dload", dload, 0);
      tick(); dWEN = 0; #2;
      chk("B_idle2_iwait", iwait, 1);
      tick(); #2;
      chk("B_i_ramaddr", ramaddr, 32'h80);
      chk("B_i_iwait", iwait, 0);
      chk("B_i_iload", iload, 32'h11111111);
      chk("B_i_ramstore", ramstore, 0);
      tick(); iREN = 0;

      // busy/error stall
      tick(); iREN = 1; iaddr = 32'h200; ramstate = 1; #2;
      for (int k = 0; k < 4; k++) begin
         tick(); ramstate = stall_seq[k]; #2;
         chk($sformatf("C_iwait_%0d", k), iwait, stall_exp[k]);
         chk($sformatf("C_ramaddr_%0d", k), ramaddr, 32'h200);
      end
      tick(); iREN = 0;

      // fairness with both requesters held
      tick(); iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h88; ramstate = 2; #2;
      for (int k = 0; k < 17; k++) begin
         if (k > 0) begin @(posedge CLK); #3; end
         if (!dwait) order.push_back("D");
         if (!iwait) order.push_back("I");
      end
      tick(); iREN = 0; dREN = 0;
      chk("D_count", order.size(), 8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("D_order_%0d", k), order[k], exp_order[k]);

      // withdraw during a data grant
      tick(); dREN = 1; iREN = 1; daddr = 32'h300; iaddr = 32'h400; ramstate = 1; #2;
      tick(); #2;
      chk("E_dgrant_ramREN", ramREN, 1);
      chk("E_dgrant_ramaddr", ramaddr, 32'h300);
      tick(); dREN = 0; #2;
      chk("E_withdraw_ramREN", ramREN, 0);
      chk("E_withdraw_waits", {iwait, dwait}, 2'b11);
      tick(); #2;
      chk("E_idle_ramaddr", ramaddr, 0);
      tick(); #2;
      chk("E_igrant_ramaddr", ramaddr, 32'h400);
      chk("E_igrant_ramREN", ramREN, 1);
      tick(); ramstate = 2; #2;
      chk("E_igrant_iwait", iwait, 0);
      tick(); iREN = 0;

      // async reset pulse in an instruction BUSY cycle
      tick(); iREN = 1; iaddr = 32'h500; ramstate = 1; #2;
      tick(); #1;
      chk("F_busy_ramREN", ramREN, 1);
      chk("F_busy_ramaddr", ramaddr, 32'h500);
      nRST = 0; #1;
      chk("F_rst_ramREN", ramREN, 0);
      chk("F_rst_ramaddr", ramaddr, 0);
      chk("F_rst_iwait", iwait, 1);
      nRST = 1; dREN = 1; daddr = 32'h600;
      tick(); #2;
      chk("F_next_ramaddr", ramaddr, 32'h600);
      chk("F_next_ramREN", ramREN, 1);
      tick(); iREN = 0; dREN = 0;

      // randomized traffic
      tick();
      rand_en = 1;
      repeat (4000) @(posedge CLK);
      rand_en = 0;
      tick(); iREN = 0; dREN = 0; dWEN = 0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
